seq_calculator: RTL and testbench
=================================

# seq_calculator

Parametrised, clocked successor to the team's 4-bit combinational calculator. It accepts two unsigned WIDTH-bit operands and a 3-bit opcode through a start/done handshake. It computes add, subtract, multiply, divide, bitwise and compare operations, and returns a registered 2*WIDTH-bit result with status flags. Multiply and divide are iterative (one bit per cycle), so the block is a small multicycle datapath for use where a single-cycle multiplier/divider is too costly.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2); result is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- oper  in  3  opcode.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle pulse; out and flags are valid from this cycle on.
- out  out  2*WIDTH  registered result.
- carry  out  1  add: carry-out; sub: borrow (a<b); 0 otherwise.
- zero  out  1  out == 0.
- err  out  1  divide by zero.

## Operation
- FSM states:
  - IDLE: start=1 latches a, b, oper and goes to CALC. start=0 stays in IDLE.
  - CALC: single-cycle ops go to DONE next edge. Mul/div run WIDTH iterations, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Operands are latched at acceptance. Input changes after acceptance have no effect.
- Opcodes (unsigned, results zero-extended to 2*WIDTH unless stated):
  - 000 add: out = a+b (WIDTH+1 significant bits); carry = bit WIDTH.
  - 001 sub: out = a−b as two's complement sign-extended to 2*WIDTH; carry = (a<b).
  - 010 mul: out = a*b, shift-add, one bit of b per cycle.
  - 011 div: out = {remainder, quotient}, each WIDTH bits, restoring division, one quotient bit per cycle.
  - 100 and, 101 or, 110 xor: bitwise on a, b, zero-extended.
  - 111 compare: out[2:0] = {a<b, a==b, a>b}; other bits 0.
- Divide by zero (oper=011, b=0): no iterations. Goes CALC→DONE in one cycle with out = all ones and err=1.
- out, carry, zero and err update only on the edge entering DONE. They hold until the next result is written.
- start while busy (CALC or DONE) is ignored and not queued.

## Timing
- Reset (async assert, any state): FSM→IDLE; busy=0, done=0, out=0, carry=0, zero=0, err=0; iteration counter and operand registers cleared. Any in-flight operation is discarded with no done pulse. Deassertion is synchronous to clk by the system; the first edge after release samples start.
- Start accepted at edge k: busy=1 from edge k.
- Single-cycle ops and div-by-zero: DONE entered at edge k+1; done high for cycle k+1→k+2; IDLE at edge k+2.
- Mul/div: iterations at edges k+1..k+WIDTH; DONE entered at edge k+WIDTH; IDLE at k+WIDTH+1.
- Back-to-back: start high in the first IDLE cycle is accepted. Minimum issue interval is 3 cycles for single-cycle ops and WIDTH+2 for mul/div.
- Iteration counter is ceil(log2(WIDTH+1)) bits and does not wrap during a valid operation.

## Test plan
- WIDTH=8, add a=255, b=6, start pulse at edge k: done at k+1, out=0x0105, carry=1, zero=0; busy low after k+2.
- Sub a=6, b=15: out=0xFFF7, carry=1. Then sub a=9, b=9: out=0x0000, zero=1, carry=0.
- Mul a=255, b=255: busy for 9 cycles, done after edge k+8, out=0xFE01. Changing a/b during CALC does not alter the result.
- Div a=200, b=7: done after k+8, out=0x041C, err=0. Then div a=5, b=0: done after k+1, out=0xFFFF, err=1.
- Start held high continuously during a mul: only one done pulse per operation; the next operation is accepted only in IDLE. Compare a=3, b=9 gives out=0x0004.
- rst_n pulsed low at iteration 4 of a mul: all outputs 0 immediately and no done pulse. A fresh add 1+1 afterwards gives out=0x0002 at k+1. Repeat add/compare checks with WIDTH=4 (a=15, b=6 → add out=0x15, carry=1).

Source files
------------

// File: rtl/seq_calculator.sv
// Multicycle calculator: add/sub/logic/compare finish in one cycle, while
// multiply (shift-add) and divide (restoring) produce one bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | evaluating; mul/div iterate WIDTH times using a down-counter
// DONE  | result registered, done pulses for one cycle
`timescale 1ns/1ps
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         oper,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2:0]         op_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH:0]     mac;
  logic [WIDTH:0]     rs;
  logic [WIDTH:0]     rd;
  logic               div_ge;
  logic [2*WIDTH-1:0] p_mul;
  logic [2*WIDTH-1:0] p_div;
  logic               div_zero;
  logic               iterative;
  logic               last_iter;
  logic [2*WIDTH-1:0] res_val;
  logic               res_carry;
  logic               res_err;

  // p holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    sum_w     = {1'b0, a_r} + {1'b0, b_r};
    diff_w    = {1'b0, a_r} - {1'b0, b_r};
    mac       = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    p_mul     = {mac, p[WIDTH-1:1]};
    rs        = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    rd        = rs - {1'b0, b_r};
    div_ge    = (rs >= {1'b0, b_r});
    p_div     = {(div_ge ? rd[WIDTH-1:0] : rs[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
    div_zero  = (op_r == OP_DIV) && (b_r == '0);
    iterative = ((op_r == OP_MUL) || (op_r == OP_DIV)) && !div_zero;
    last_iter = (cnt == CW'(1));

    res_val   = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (op_r)
      OP_ADD: begin
        res_val   = {{(WIDTH-1){1'b0}}, sum_w};
        res_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        res_val   = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
        res_carry = diff_w[WIDTH];
      end
      OP_MUL: res_val = p_mul;
      OP_DIV: begin
        if (div_zero) begin
          res_val = '1;
          res_err = 1'b1;
        end else begin
          res_val = p_div;
        end
      end
      OP_AND: res_val = {{WIDTH{1'b0}}, a_r & b_r};
      OP_OR:  res_val = {{WIDTH{1'b0}}, a_r | b_r};
      OP_XOR: res_val = {{WIDTH{1'b0}}, a_r ^ b_r};
      OP_CMP: res_val = {{(2*WIDTH-3){1'b0}}, (a_r < b_r), (a_r == b_r), (a_r > b_r)};
      default: res_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= oper;
            p     <= {{WIDTH{1'b0}}, ((oper == OP_DIV) ? a : b)};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (iterative && !last_iter) begin
            p   <= res_val;
            cnt <= cnt - CW'(1);
          end else begin
            // last iteration (or single-cycle op) lands straight in the output
            p     <= res_val;
            cnt   <= '0;
            out   <= res_val;
            carry <= res_carry;
            zero  <= (res_val == '0);
            err   <= res_err;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Bench for seq_calculator at WIDTH=8 and WIDTH=4: vector tables feed a
// per-instance scoreboard, plus hand sequences for held start and mid-op reset.
`timescale 1ns/1ps
module tb_seq_calculator;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [2:0]  op8 = '0, op4 = '0;
  logic        busy8, done8, carry8, zero8, err8;
  logic        busy4, done4, carry4, zero4, err4;
  logic [15:0] out8;
  logic [7:0]  out4;

  int   checks = 0;
  int   failures = 0;
  vec_t q8[$];
  vec_t q4[$];
  vec_t e8, e4;
  vec_t tbl8[18];
  vec_t tbl4[7];

  always #5 clk = ~clk;

  seq_calculator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .oper(op8),
    .busy(busy8), .done(done8), .out(out8), .carry(carry8), .zero(zero8), .err(err8)
  );

  seq_calculator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .oper(op4),
    .busy(busy4), .done(done4), .out(out4), .carry(carry4), .zero(zero4), .err(err4)
  );

  function automatic vec_t mk(string nm, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                              logic [15:0] res, logic c, logic z, logic e, int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.res = res;
    v.c = c; v.z = z; v.e = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done8 actual=1 expected=0");
      end else begin
        e8 = q8.pop_front();
        check({e8.nm, "_out"},   out8,          e8.res);
        check({e8.nm, "_carry"}, 16'(carry8),   16'(e8.c));
        check({e8.nm, "_zero"},  16'(zero8),    16'(e8.z));
        check({e8.nm, "_err"},   16'(err8),     16'(e8.e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done4 actual=1 expected=0");
      end else begin
        e4 = q4.pop_front();
        check({e4.nm, "_out"},   {8'h00, out4}, e4.res);
        check({e4.nm, "_carry"}, 16'(carry4),   16'(e4.c));
        check({e4.nm, "_zero"},  16'(zero4),    16'(e4.z));
        check({e4.nm, "_err"},   16'(err4),     16'(e4.e));
      end
    end
  end

  // Issue one op, scramble inputs while it runs, check latency and return to idle.
  task automatic run(input bit w4, input vec_t v);
    int n;
    bit got;
    @(negedge clk);
    if (w4) begin
      a4 = v.a[3:0]; b4 = v.b[3:0]; op4 = v.op; start4 = 1'b1;
      q4.push_back(v);
    end else begin
      a8 = v.a; b8 = v.b; op8 = v.op; start8 = 1'b1;
      q8.push_back(v);
    end
    @(posedge clk); #1;
    if (w4) begin
      start4 = 1'b0;
      check({v.nm, "_busy"}, 16'(busy4), 16'd1);
      a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
    end else begin
      start8 = 1'b0;
      check({v.nm, "_busy"}, 16'(busy8), 16'd1);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = w4 ? done4 : done8;
    end
    check({v.nm, "_latency"}, 16'(n), 16'(v.lat + 1));
    @(posedge clk); #1;
    check({v.nm, "_idle_busy"}, 16'(w4 ? busy4 : busy8), 16'd0);
    check({v.nm, "_idle_done"}, 16'(w4 ? done4 : done8), 16'd0);
  endtask

  initial begin
    int n, dn, first;

    tbl8[0]  = mk("add_255_6",   3'b000, 8'd255, 8'd6,   16'h0105, 1, 0, 0, 1);
    tbl8[1]  = mk("add_0_0",     3'b000, 8'd0,   8'd0,   16'h0000, 0, 1, 0, 1);
    tbl8[2]  = mk("sub_6_15",    3'b001, 8'd6,   8'd15,  16'hFFF7, 1, 0, 0, 1);
    tbl8[3]  = mk("sub_9_9",     3'b001, 8'd9,   8'd9,   16'h0000, 0, 1, 0, 1);
    tbl8[4]  = mk("sub_200_100", 3'b001, 8'd200, 8'd100, 16'h0064, 0, 0, 0, 1);
    tbl8[5]  = mk("mul_255_255", 3'b010, 8'd255, 8'd255, 16'hFE01, 0, 0, 0, 8);
    tbl8[6]  = mk("mul_0_77",    3'b010, 8'd0,   8'd77,  16'h0000, 0, 1, 0, 8);
    tbl8[7]  = mk("mul_12_13",   3'b010, 8'd12,  8'd13,  16'h009C, 0, 0, 0, 8);
    tbl8[8]  = mk("div_200_7",   3'b011, 8'd200, 8'd7,   16'h041C, 0, 0, 0, 8);
    tbl8[9]  = mk("div_5_0",     3'b011, 8'd5,   8'd0,   16'hFFFF, 0, 0, 1, 1);
    tbl8[10] = mk("div_3_10",    3'b011, 8'd3,   8'd10,  16'h0300, 0, 0, 0, 8);
    tbl8[11] = mk("div_255_1",   3'b011, 8'd255, 8'd1,   16'h00FF, 0, 0, 0, 8);
    tbl8[12] = mk("and",         3'b100, 8'hF0,  8'h3C,  16'h0030, 0, 0, 0, 1);
    tbl8[13] = mk("or",          3'b101, 8'hF0,  8'h0F,  16'h00FF, 0, 0, 0, 1);
    tbl8[14] = mk("xor",         3'b110, 8'hAA,  8'hAA,  16'h0000, 0, 1, 0, 1);
    tbl8[15] = mk("cmp_3_9",     3'b111, 8'd3,   8'd9,   16'h0004, 0, 0, 0, 1);
    tbl8[16] = mk("cmp_9_9",     3'b111, 8'd9,   8'd9,   16'h0002, 0, 0, 0, 1);
    tbl8[17] = mk("cmp_10_2",    3'b111, 8'd10,  8'd2,   16'h0001, 0, 0, 0, 1);

    tbl4[0] = mk("w4_add_15_6",  3'b000, 8'd15, 8'd6, 16'h0015, 1, 0, 0, 1);
    tbl4[1] = mk("w4_cmp_15_6",  3'b111, 8'd15, 8'd6, 16'h0001, 0, 0, 0, 1);
    tbl4[2] = mk("w4_sub_2_5",   3'b001, 8'd2,  8'd5, 16'h00FD, 1, 0, 0, 1);
    tbl4[3] = mk("w4_mul_15_15", 3'b010, 8'd15, 8'd15, 16'h00E1, 0, 0, 0, 4);
    tbl4[4] = mk("w4_div_13_4",  3'b011, 8'd13, 8'd4, 16'h0013, 0, 0, 0, 4);
    tbl4[5] = mk("w4_div_9_0",   3'b011, 8'd9,  8'd0, 16'h00FF, 0, 0, 1, 1);
    tbl4[6] = mk("w4_add_0_0",   3'b000, 8'd0,  8'd0, 16'h0000, 0, 1, 0, 1);

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",  16'(busy8),  16'd0);
    check("rst_done",  16'(done8),  16'd0);
    check("rst_out",   out8,        16'd0);
    check("rst_carry", 16'(carry8), 16'd0);
    check("rst_zero",  16'(zero8),  16'd0);
    check("rst_err",   16'(err8),   16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) run(1'b0, tbl8[i]);
    for (int i = 0; i < 7; i++) run(1'b1, tbl4[i]);

    // start held high across a mul: exactly one accept per trip through IDLE
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; op8 = 3'b010; start8 = 1'b1;
    q8.push_back(mk("hold_mul", 3'b010, 8'd3, 8'd5, 16'h000F, 0, 0, 0, 8));
    @(posedge clk); #1;
    a8 = 8'd3; b8 = 8'd9; op8 = 3'b111;
    q8.push_back(mk("hold_cmp", 3'b111, 8'd3, 8'd9, 16'h0004, 0, 0, 0, 1));
    n = 0; dn = 0; first = 0;
    while (dn < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (done8) begin
        dn++;
        if (dn == 1) first = n;
      end
    end
    start8 = 1'b0;
    check("hold_first_done_cycle",  16'(first), 16'd9);
    check("hold_second_done_cycle", 16'(n),     16'd12);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("hold_no_extra_done", 16'(dn),    16'd0);
    check("hold_idle_busy",     16'(busy8), 16'd0);

    // reset during iteration 4 of a mul
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; op8 = 3'b010; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",  16'(busy8),  16'd0);
    check("midrst_done",  16'(done8),  16'd0);
    check("midrst_out",   out8,        16'd0);
    check("midrst_carry", 16'(carry8), 16'd0);
    check("midrst_zero",  16'(zero8),  16'd0);
    check("midrst_err",   16'(err8),   16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("midrst_no_done", 16'(dn), 16'd0);
    run(1'b0, mk("post_rst_add", 3'b000, 8'd1, 8'd1, 16'h0002, 0, 0, 0, 1));

    check("sb8_empty", 16'(q8.size()), 16'd0);
    check("sb4_empty", 16'(q4.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
